// File: rtl/transform_schedule.sv
// In-place radix-2 DIF FFT stage sequencer; results land in bit-reversed order.
// Define TRANSFORM_SCHEDULE_SCALE_EN for 1/2 scaling per stage, otherwise write-back saturates.
module transform_schedule #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [LOG2N-1:0]       rd_addr_a,
  output logic [LOG2N-1:0]       rd_addr_b,
  output logic [LOG2N-2:0]       tw_addr,
  input  logic [2*WIDTH-1:0]     rd_data_a,
  input  logic [2*WIDTH-1:0]     rd_data_b,
  input  logic [2*WIDTH-1:0]     tw_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [6*WIDTH-1:0]     b_data,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [4*WIDTH+3:0]     r_data,
  output logic                   wr_en,
  output logic [LOG2N-1:0]       wr_addr_a,
  output logic [LOG2N-1:0]       wr_addr_b,
  output logic [2*WIDTH-1:0]     wr_data_a,
  output logic [2*WIDTH-1:0]     wr_data_b
);

  localparam int RE = 2*WIDTH + 2;
  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [LOG2N-1:0] HALF  = {1'b1, {(LOG2N-1){1'b0}}};
  localparam logic [SW-1:0]    S_LM1 = SW'(LOG2N - 1);
  localparam logic [SW-1:0]    S_L   = SW'(LOG2N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Reduce one WIDTH+1 butterfly component to a WIDTH-bit stored component.
  function automatic logic [WIDTH-1:0] f_wb(input logic signed [WIDTH:0] c);
`ifdef TRANSFORM_SCHEDULE_SCALE_EN
    f_wb = c[WIDTH:1];
`else
    if (!c[WIDTH] && c[WIDTH-1])
      f_wb = {1'b0, {(WIDTH-1){1'b1}}};
    else if (c[WIDTH] && !c[WIDTH-1])
      f_wb = {1'b1, {(WIDTH-1){1'b0}}};
    else
      f_wb = c[WIDTH-1:0];
`endif
  endfunction

  state_t                 r_state, w_state_nx;
  logic [SW-1:0]          r_stage, w_stage_nx;
  logic [KW-1:0]          r_k, w_k_nx;
  logic                   r_inflight;
  logic [CW-1:0]          r_out;
  logic [PW-1:0]          r_af_wp, r_af_rp;
  logic [2*LOG2N-1:0]     r_af_mem [DEPTH];
  logic [1:0]             r_ib_cnt;
  logic                   r_ib_wp, r_ib_rp;
  logic [6*WIDTH-1:0]     r_ib_mem [2];

  logic [LOG2N-1:0]       w_kx, w_span, w_mask, w_a, w_b;
  logic [KW-1:0]          w_tw;
  logic [2:0]             w_ib_level;
  logic                   w_rd_ok, w_ib_pop, w_af_pop, w_drained;
  logic [2*LOG2N-1:0]     w_af_head;
  logic [WIDTH:0]         w_re0, w_im0, w_re1, w_im1;

  // Stage 0: address generation and read issue
  assign w_kx   = LOG2N'(r_k);
  assign w_span = HALF >> r_stage;
  assign w_mask = w_span - LOG2N'(1);
  assign w_a    = ((w_kx >> (S_LM1 - r_stage)) << (S_L - r_stage)) | (w_kx & w_mask);
  assign w_b    = w_a + w_span;
  assign w_tw   = KW'((w_kx & w_mask) << r_stage);

  // Slots still free once this cycle's pop and the pending read have landed.
  assign w_ib_pop   = b_valid && b_ready;
  assign w_ib_level = 3'(r_ib_cnt) + 3'(r_inflight) - 3'(w_ib_pop);
  assign w_rd_ok    = (r_state == S_RUN) && (r_out < CW'(DEPTH)) && (w_ib_level < 3'd2);

  assign rd_en     = w_rd_ok;
  assign rd_addr_a = w_rd_ok ? w_a  : '0;
  assign rd_addr_b = w_rd_ok ? w_b  : '0;
  assign tw_addr   = w_rd_ok ? w_tw : '0;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign w_drained = (r_out == '0) && (r_ib_cnt == 2'd0) && !r_inflight;

  always_comb begin
    w_state_nx = r_state;
    w_stage_nx = r_stage;
    w_k_nx     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_stage_nx = '0;
          w_k_nx     = '0;
        end
      end
      S_RUN: begin
        if (w_rd_ok) begin
          if (&r_k) w_state_nx = S_DRAIN;
          else      w_k_nx     = r_k + KW'(1);
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          if (r_stage == S_LM1) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_RUN;
            w_stage_nx = r_stage + SW'(1);
            w_k_nx     = '0;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_stage    <= '0;
      r_k        <= '0;
      r_inflight <= 1'b0;
      r_out      <= '0;
      r_af_wp    <= '0;
      r_af_rp    <= '0;
      r_ib_cnt   <= 2'd0;
      r_ib_wp    <= 1'b0;
      r_ib_rp    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_stage    <= w_stage_nx;
      r_k        <= w_k_nx;
      r_inflight <= w_rd_ok;
      r_out      <= r_out + CW'(w_rd_ok) - CW'(w_af_pop);
      if (w_rd_ok)    r_af_wp <= r_af_wp + PW'(1);
      if (w_af_pop)   r_af_rp <= r_af_rp + PW'(1);
      r_ib_cnt   <= r_ib_cnt + 2'(r_inflight) - 2'(w_ib_pop);
      if (r_inflight) r_ib_wp <= ~r_ib_wp;
      if (w_ib_pop)   r_ib_rp <= ~r_ib_rp;
    end
  end

  // Stage 1: memory/ROM data captured into the issue buffer
  always_ff @(posedge clk) begin
    if (w_rd_ok)    r_af_mem[r_af_wp] <= {w_a, w_b};
    if (r_inflight) r_ib_mem[r_ib_wp] <= {tw_data, rd_data_b, rd_data_a};
  end

  assign b_valid = (r_ib_cnt != 2'd0);
  assign b_data  = b_valid ? r_ib_mem[r_ib_rp] : '0;

  // Write-back: result returns paired with the oldest outstanding address pair
  assign r_ready   = 1'b1;
  assign w_af_pop  = r_valid && (r_out != '0);
  assign w_af_head = r_af_mem[r_af_rp];

  assign w_re0 = r_data[0*RE +: WIDTH+1];
  assign w_im0 = r_data[0*RE+WIDTH+1 +: WIDTH+1];
  assign w_re1 = r_data[1*RE +: WIDTH+1];
  assign w_im1 = r_data[1*RE+WIDTH+1 +: WIDTH+1];

  assign wr_en     = r_valid;
  assign wr_addr_a = r_valid ? w_af_head[2*LOG2N-1:LOG2N] : '0;
  assign wr_addr_b = r_valid ? w_af_head[LOG2N-1:0]       : '0;
  assign wr_data_a = r_valid ? {f_wb(w_re0), f_wb(w_im0)} : '0;
  assign wr_data_b = r_valid ? {f_wb(w_re1), f_wb(w_im1)} : '0;

endmodule

// File: tb/tb_transform_schedule.sv
// Scoreboard bench for transform_schedule (N=8, DEPTH=4, butterfly latency 9).
module tb_transform_schedule;
  localparam int WIDTH = 16;
  localparam int LOG2N = 3;
  localparam int DEPTH = 4;
  localparam int L     = 9;
  localparam int N     = 8;

`ifdef TRANSFORM_SCHEDULE_SCALE_EN
  localparam logic [31:0] IMP_V = 32'h0800_0000;
  localparam logic [31:0] DC0_V = 32'h1000_0000;
`else
  localparam logic [31:0] IMP_V = 32'h4000_0000;
  localparam logic [31:0] DC0_V = 32'h7FFF_0000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic b_ready = 1'b1;
  logic busy, done, rd_en, b_valid, r_valid, r_ready, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic [31:0] rd_data_a = '0, rd_data_b = '0, tw_data = '0;
  logic [31:0] wr_data_a, wr_data_b;
  logic [95:0] b_data;
  logic [67:0] r_data;

  always #5 clk = ~clk;

  transform_schedule #(.WIDTH(WIDTH), .LOG2N(LOG2N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  // exp(-j*2*pi*m/8) in Q1.15, {real, imag}
  logic [31:0] tw_rom [4] = '{32'h7FFF_0000, 32'h5A82_A57E, 32'h0000_8001, 32'hA57E_A57E};
  logic [31:0] mem [N];
  logic [31:0] ld_buf [N];
  logic [31:0] ref_m [N];
  logic        ld_req = 1'b0;
  logic        bp_en = 1'b0;
  logic        addr_chk = 1'b0;

  int nchk = 0, nerr = 0;
  int done_cnt = 0, rd_cnt = 0, osd = 0, osd_max = 0;
  logic [95:0] bq [$];
  logic [7:0]  aq [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [67:0] bf(input logic [95:0] d);
    logic signed [16:0] ar, ai, br, bi, sr, si, dr, di, qr, qi;
    logic signed [15:0] wr, wi;
    logic signed [33:0] pr, pi;
    ar = {d[31], d[31:16]}; ai = {d[15], d[15:0]};
    br = {d[63], d[63:48]}; bi = {d[47], d[47:32]};
    wr = d[95:80];          wi = d[79:64];
    sr = ar + br; si = ai + bi;
    dr = ar - br; di = ai - bi;
    pr = 34'(dr) * 34'(wr) - 34'(di) * 34'(wi);
    pi = 34'(dr) * 34'(wi) + 34'(di) * 34'(wr);
    qr = 17'((pr + 34'sd16384) >>> 15);
    qi = 17'((pi + 34'sd16384) >>> 15);
    return {qi, qr, si, sr};
  endfunction

  function automatic logic [15:0] wb(input logic [16:0] c);
`ifdef TRANSFORM_SCHEDULE_SCALE_EN
    return c[16:1];
`else
    int v;
    v = $signed(c);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return c[15:0];
`endif
  endfunction

  // Textbook in-place DIF: groups of 2*span, twiddle index j<<s.
  task automatic ref_fft();
    for (int s = 0; s < LOG2N; s++) begin
      int span;
      span = N >> (s + 1);
      for (int g = 0; g < N; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int a;
          int b;
          logic [67:0] r;
          a = g + j;
          b = a + span;
          r = bf({tw_rom[j << s], ref_m[b], ref_m[a]});
          ref_m[a] = {wb(r[16:0]),  wb(r[33:17])};
          ref_m[b] = {wb(r[50:34]), wb(r[67:51])};
        end
      end
    end
  endtask

  // Sample memory, twiddle ROM and loader
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      tw_data   <= tw_rom[tw_addr];
    end
    if (ld_req) begin
      for (int i = 0; i < N; i++) mem[i] <= ld_buf[i];
    end else if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
  end

  // Butterfly datapath model, fixed latency L, reset together with the DUT
  logic [L-1:0] pv;
  logic [67:0]  pd [L];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pv <= '0;
    else          pv <= {pv[L-2:0], b_valid && b_ready};
  end
  always @(posedge clk) begin
    pd[0] <= bf(b_data);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign r_valid = pv[L-1];
  assign r_data  = pd[L-1];

  initial begin
    forever begin
      @(posedge clk);
      #1 b_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (r_valid && osd == 0) begin
        nchk++; nerr++;
        $display("FAIL orphan_result: r_valid=1 with outstanding=0, required outstanding>0");
      end
      if (rd_en) begin
        rd_cnt++;
        bq.push_back({tw_rom[tw_addr], mem[rd_addr_b], mem[rd_addr_a]});
        if (addr_chk) begin
          if (aq.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL rd_addr: extra read a=%0d b=%0d tw=%0d, required none", rd_addr_a, rd_addr_b, tw_addr);
          end else begin
            chk("rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, aq.pop_front());
          end
        end
      end
      if (b_valid && b_ready) begin
        if (bq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL b_data: issue %0h with no read behind it", b_data);
        end else begin
          chk("b_data", b_data, bq.pop_front());
        end
      end
      osd = osd + (rd_en ? 1 : 0) - (r_valid ? 1 : 0);
      if (osd > osd_max) osd_max = osd;
    end
  end

  task automatic chk_idle(input string t);
    chk({t, "_busy"},    busy, 0);
    chk({t, "_done"},    done, 0);
    chk({t, "_rd_en"},   rd_en, 0);
    chk({t, "_b_valid"}, b_valid, 0);
    chk({t, "_wr_en"},   wr_en, 0);
    chk({t, "_r_ready"}, r_ready, 1);
    chk({t, "_rd_addr"}, {rd_addr_a, rd_addr_b, tw_addr}, 0);
    chk({t, "_b_data"},  b_data, 0);
    chk({t, "_wr_bus"},  {wr_addr_a, wr_addr_b, wr_data_a, wr_data_b}, 0);
  endtask

  task automatic do_load();
    @(posedge clk); #1 ld_req = 1'b1;
    @(posedge clk); #1 ld_req = 1'b0;
  endtask

  task automatic rand_load();
    for (int i = 0; i < N; i++) begin
      ld_buf[i] = {16'($urandom_range(0, 16383)) - 16'h2000, 16'($urandom_range(0, 16383)) - 16'h2000};
      ref_m[i]  = ld_buf[i];
    end
    ref_fft();
  endtask

  task automatic run_tf(input bit busy_start);
    int w;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk);
      chk("busy_in_run", busy, 1);
      @(posedge clk); #1 start = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == 0) begin
      nchk++; nerr++;
      $display("FAIL done_timeout: no done after %0d cycles, required done", w);
    end
    repeat (20) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_after", busy, 0);
    chk("issue_queue_empty", bq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int tb [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int tt [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    int w;

    repeat (2) @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Impulse plus address sequence
    for (int i = 0; i < N; i++) ld_buf[i] = '0;
    ld_buf[0] = 32'h4000_0000;
    do_load();
    for (int i = 0; i < 12; i++) aq.push_back({3'(ta[i]), 3'(tb[i]), 2'(tt[i])});
    addr_chk = 1'b1;
    run_tf(1'b0);
    addr_chk = 1'b0;
    chk("addr_all_seen", aq.size(), 0);
    for (int i = 0; i < N; i++) chk($sformatf("impulse_%0d", i), mem[i], IMP_V);

    // DC with a start pulse while busy
    for (int i = 0; i < N; i++) ld_buf[i] = 32'h1000_0000;
    do_load();
    run_tf(1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("dc_%0d", i), mem[i], (i == 0) ? DC0_V : 32'h0);

    // Random data under 30% b_ready
    rand_load();
    do_load();
    bp_en = 1'b1;
    osd_max = 0;
    run_tf(1'b0);
    bp_en = 1'b0;
    nchk++;
    if (osd_max > DEPTH) begin
      nerr++;
      $display("FAIL max_outstanding: got %0d required <= %0d", osd_max, DEPTH);
    end
    for (int i = 0; i < N; i++) chk($sformatf("bp_fft_%0d", i), mem[i], ref_m[i]);

    // Reset during stage 1, then a clean transform
    rand_load();
    do_load();
    rd_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (rd_cnt < 6 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (rd_cnt < 6) begin
      nchk++; nerr++;
      $display("FAIL stage1_wait: got %0d reads required 6", rd_cnt);
    end
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk_idle("midreset");
    bq.delete();
    osd = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    do_load();
    run_tf(1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("post_reset_fft_%0d", i), mem[i], ref_m[i]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/transform_schedule.md
# transform_schedule

In-place radix-2 decimation-in-frequency FFT stage sequencer. It walks all LOG2N stages over a dual-port sample memory, fetches operand pairs and twiddles, and issues them to the shared butterfly datapath over a valid/ready stream. It writes butterfly results back to the same addresses and signals completion. Output is in bit-reversed order.

## Interface
- `WIDTH`, 16: bits per real/imag component; samples are `{real, imag}`, 2*WIDTH bits.
- `LOG2N`, 6: log2 of transform length N.
- `DEPTH`, 8: maximum butterflies outstanding (issued, not yet written back); power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin transform; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `rd_en`  out  1  read strobe, both memory ports plus twiddle ROM.
- `rd_addr_a`, `rd_addr_b`  out  LOG2N  operand addresses.
- `tw_addr`  out  LOG2N-1  twiddle ROM index.
- `rd_data_a`, `rd_data_b`, `tw_data`  in  2*WIDTH  valid the cycle after `rd_en`.
- `b_valid`  out  1 / `b_ready`  in  1 / `b_data`  out  3×2*WIDTH  butterfly issue `{tw, b, a}`.
- `r_valid`  in  1 / `r_ready`  out  1 / `r_data`  in  2×(2*WIDTH+2)  butterfly result; element 0 = a+b, element 1 = (a−b)·tw, each `{imag, real}` of WIDTH+1 bits.
- `wr_en`  out  1; `wr_addr_a`, `wr_addr_b`  out  LOG2N; `wr_data_a`, `wr_data_b`  out  2*WIDTH.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + `start` → RUN with stage s=0, index k=0.
- RUN issues one read per cycle when permitted.
  - After k=N/2−1 is issued → DRAIN.
- DRAIN waits until outstanding==0 and the issue buffer is empty.
  - If s==LOG2N−1 → DONE; else s+1, k=0 → RUN.
- DONE lasts one cycle with `done`=1, then → IDLE.
- `start` outside IDLE is ignored.
- Addressing, with span=N>>(s+1):
  - a = ((k>>(LOG2N−1−s))<<(LOG2N−s)) | (k & (span−1)).
  - b = a + span.
  - tw_addr = (k & (span−1))<<s.
- Read permitted when: state RUN, outstanding < DEPTH, and (issue buffer entries + reads in flight) < 2.
- Issue buffer: 2-entry FIFO capturing `{tw_data, rd_data_b, rd_data_a}` the cycle after `rd_en`. `b_valid` = buffer non-empty.
- Address FIFO (DEPTH entries): `{a, b}` pushed on `rd_en`, popped on `r_valid`.
- Outstanding counter: +1 on `rd_en`, −1 on `r_valid`. Simultaneous events give a net 0.
- `r_ready` = 1 constant. `wr_en` = `r_valid`, with addresses taken from the address FIFO head (combinational).
- `r_valid` with an empty address FIFO is an error; the bench asserts it never occurs.
- Writeback width reduction is set by the configuration macro.
- Reset mid-transform aborts immediately: state IDLE, FIFOs empty, counters 0. The top level resets the butterfly datapath concurrently.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `b_valid`, `wr_en` = 0; `r_ready` = 1; all addresses and data = 0.
- `start` high at edge t → RUN at t+1 → `rd_en` can be asserted in cycle t+1.
- `rd_en` in cycle t → buffer write at edge t+1 → `b_valid` from cycle t+2.
- With `b_ready`=1, sustained throughput is one butterfly per cycle.
- Write-back occurs in the same cycle as `r_valid`.
- With butterfly latency L and `b_ready`=1, each stage takes N/2 + L + 3 cycles, ±1 for state transitions.

## Configuration
- `TRANSFORM_SCHEDULE_SCALE_EN` defined:
  - Each stage scales by 1/2. The written component is `r_data` component bits [WIDTH:1], truncating the LSB; overflow is impossible.
- Undefined:
  - No scaling. Each WIDTH+1 component saturates to WIDTH bits: values above 2^(WIDTH−1)−1 clamp to 0x7FFF, values below −2^(WIDTH−1) clamp to 0x8000 (WIDTH=16).

## Test plan
- Impulse with scale on: LOG2N=3, x[0]=0x4000+j0, others 0 → `done` once; all 8 words = 0x0800+j0.
- DC with scale off: all x=0x1000+j0 → addr 0 real = 0x7FFF (saturated); all other words 0.
- Address sequence: LOG2N=3 → stage 0 pairs (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3; stage 1 pairs (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage 2 pairs (0,1)(2,3)(4,5)(6,7) tw 0.
- Backpressure: `b_ready` random 30% duty, L=9, DEPTH=4 → outstanding never exceeds 4; results match a bit-reversed reference FFT model.
- Reset mid-stage: deassert then reassert `reset_n` during stage 1 → all outputs at reset values; a new `start` completes a correct transform.
- `start` while busy: pulse during RUN → ignored, exactly one `done`.
